// File: rtl/aes_ks_pkg.sv
// Shared AES key-schedule helpers: S-box, Rcon and key-length derived sizes.
package aes_ks_pkg;

   function automatic int unsigned nk_of(input int unsigned keylen);
      return keylen / 32;
   endfunction

   function automatic int unsigned nr_of(input int unsigned keylen);
      return nk_of(keylen) + 6;
   endfunction

   // Each stage produces four words; the key itself supplies the first NK.
   function automatic int unsigned nstage_of(input int unsigned keylen);
      return (4 * (nr_of(keylen) + 1) - nk_of(keylen) + 3) / 4;
   endfunction

   function automatic logic [7:0] rcon(input int unsigned idx);
      logic [7:0] rc;
      case (idx)
         1:       rc = 8'h01;
         2:       rc = 8'h02;
         3:       rc = 8'h04;
         4:       rc = 8'h08;
         5:       rc = 8'h10;
         6:       rc = 8'h20;
         7:       rc = 8'h40;
         8:       rc = 8'h80;
         9:       rc = 8'h1b;
         10:      rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] bb;
      p  = '0;
      x  = a;
      bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ x;
         x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 followed by the FIPS-197 affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      logic [7:0] inv;
      x   = a;
      inv = 8'h01;
      for (int k = 0; k < 7; k++) begin
         x   = gf_mul(x, x);
         inv = gf_mul(inv, x);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_ks_step.sv
// One key-expansion step: derives words START..START+3 from the words already in the window.
module aes_ks_step
   import aes_ks_pkg::*;
#(
   parameter int unsigned NK    = 4,
   parameter int unsigned START = 4,
   parameter int unsigned TOT   = 44
) (
   input  logic [TOT-1:0][31:0] win,
   output logic [3:0][31:0]     wnew
);

   // Later words of the window are carried by the stage but not needed here.
   logic unused_win;
   assign unused_win = ^win;

   for (genvar k = 0; k < 4; k++) begin : g_word
      localparam int unsigned I = START + k;
      logic [31:0] word;

      if (I < TOT) begin : g_on
         logic [31:0] prev;
         logic [31:0] temp;

         if (k == 0) begin : g_prev_win
            assign prev = win[I-1];
         end else begin : g_prev_new
            assign prev = g_word[k-1].word;
         end

         if (I % NK == 0) begin : g_rot
            assign temp = sub_word(rot_word(prev)) ^ {rcon(I / NK), 24'h000000};
         end else if (NK == 8 && I % NK == 4) begin : g_sub
            assign temp = sub_word(prev);
         end else begin : g_pass
            assign temp = prev;
         end

         assign word = win[I-NK] ^ temp;
      end else begin : g_off
         // Past the last round key (KEYLEN=192 tail): nothing to generate.
         assign word = '0;
      end

      assign wnew[k] = word;
   end

endmodule

// File: rtl/aes_key_schedule_pipe.sv
// Fully pipelined AES key expansion: one key in per cycle, all round keys out together.
module aes_key_schedule_pipe
   import aes_ks_pkg::*;
#(
   parameter  int unsigned KEYLEN = 128,
   parameter  int unsigned TAG_W  = 32,
   localparam int unsigned NK     = nk_of(KEYLEN),
   localparam int unsigned NR     = nr_of(KEYLEN),
   localparam int unsigned NRK    = NR + 1,
   localparam int unsigned NSTAGE = nstage_of(KEYLEN),
   localparam int unsigned TOT    = 4 * NRK
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [KEYLEN-1:0]    in_key,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [128*NRK-1:0]   out_rk,
   output logic [TAG_W-1:0]     out_tag
);

   if (KEYLEN != 128 && KEYLEN != 192 && KEYLEN != 256) begin : g_bad_keylen
      $fatal(1, "aes_key_schedule_pipe: KEYLEN must be 128, 192 or 256");
   end

   logic [TOT-1:0][31:0] key_win;

   for (genvar j = 0; j < TOT; j++) begin : g_key
      if (j < NK) begin : g_word
         assign key_win[j] = in_key[KEYLEN-1-32*j -: 32];
      end else begin : g_zero
         assign key_win[j] = '0;
      end
   end

   // The whole pipe moves as one; only a held output can stall it.
   assign in_ready = !(out_valid && !out_ready);

   for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
      localparam int unsigned START = NK + 4 * s;

      logic [TOT-1:0][31:0] win;
      logic [TOT-1:0][31:0] nxt;
      logic [TOT-1:0][31:0] w_q;
      logic [3:0][31:0]     wnew;
      logic                 valid_in;
      logic                 valid_q;
      logic [TAG_W-1:0]     tag_in;
      logic [TAG_W-1:0]     tag_q;

      if (s == 0) begin : g_head
         assign win      = key_win;
         assign valid_in = in_valid;
         assign tag_in   = in_tag;
      end else begin : g_body
         assign win      = g_stage[s-1].w_q;
         assign valid_in = g_stage[s-1].valid_q;
         assign tag_in   = g_stage[s-1].tag_q;
      end

      aes_ks_step #(
         .NK    (NK),
         .START (START),
         .TOT   (TOT)
      ) u_step (
         .win  (win),
         .wnew (wnew)
      );

      for (genvar j = 0; j < TOT; j++) begin : g_merge
         if (j >= START && j < START + 4) begin : g_new
            assign nxt[j] = wnew[j-START];
         end else begin : g_carry
            assign nxt[j] = win[j];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            w_q     <= '0;
            tag_q   <= '0;
         end else if (in_ready) begin
            valid_q <= valid_in;
            w_q     <= nxt;
            tag_q   <= tag_in;
         end
      end
   end

   assign out_valid = g_stage[NSTAGE-1].valid_q;
   assign out_tag   = g_stage[NSTAGE-1].tag_q;

   // Round key r sits at [128r+127:128r] with its first word in the MSBs.
   for (genvar j = 0; j < TOT; j++) begin : g_out
      assign out_rk[128*(j/4) + 32*(3-(j%4)) +: 32] = g_stage[NSTAGE-1].w_q[j];
   end

endmodule

// File: tb/tb_aes_key_schedule_pipe.sv
// Scoreboard bench: one pipeline per key length, checked against a FIPS-197 software model.
module tb_aes_key_schedule_pipe;

   localparam int NKEYS = 10000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit done [3];
   logic [7:0] sbox_tab [256];

   // S-box from the generator-3 walk of GF(2^8), independent of the RTL's a^254 form.
   initial begin : build_sbox
      logic [7:0] p;
      logic [7:0] q;
      logic [7:0] x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_tab[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_tab[0] = 8'h63;
   end

   function automatic logic [31:0] sw(input logic [31:0] w);
      return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
   endfunction

   // Key right-aligned: w[0] is key[32*nk-1 -: 32].
   function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] res;
      int            nw;
      nw  = 4 * (nk + 7);
      rc  = 8'h01;
      res = '0;
      for (int j = 0; j < nk; j++) w[j] = key[32*(nk-1-j) +: 32];
      for (int i = nk; i < nw; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = sw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && i % nk == 4) begin
            t = sw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i < nw; i++) res[128*(i/4) + 32*(3-(i%4)) +: 32] = w[i];
      return res;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_kl
      localparam int KL  = 128 + 64 * g;
      localparam int NK  = KL / 32;
      localparam int NRK = NK + 7;
      localparam int NST = (4 * NRK - NK + 3) / 4;
      localparam int RKW = 128 * NRK;
      localparam logic [255:0] KAT_KEY =
         (g == 0) ? 256'h2b7e151628aed2a6abf7158809cf4f3c :
         (g == 1) ? 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b :
                    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      localparam logic [127:0] KAT_RK =
         (g == 0) ? 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 :
         (g == 1) ? 128'he98ba06f448c773c8ecc720401002202 :
                    128'hfe4890d1e6188d0b046df344706c631e;

      logic            rst_n;
      logic            in_valid;
      logic            in_ready;
      logic [KL-1:0]   in_key;
      logic [31:0]     in_tag;
      logic            out_valid;
      logic            out_ready;
      logic [RKW-1:0]  out_rk;
      logic [31:0]     out_tag;
      logic [1919:0]   exp_rk_q [$];
      logic [31:0]     exp_tag_q [$];

      aes_key_schedule_pipe #(
         .KEYLEN (KL),
         .TAG_W  (32)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_key    (in_key),
         .in_tag    (in_tag),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_rk    (out_rk),
         .out_tag   (out_tag)
      );

      initial begin : monitor
         logic           stalled;
         logic [RKW-1:0] held_rk;
         logic [31:0]    held_tag;
         logic [1919:0]  e;
         logic [RKW-1:0] ew;
         logic [31:0]    et;
         int             bad;
         stalled = 1'b0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               stalled = 1'b0;
            end else begin
               if (stalled) begin
                  chk($sformatf("k%0d hold_valid", KL), 128'(out_valid), 128'd1);
                  chk($sformatf("k%0d hold_changed", KL),
                      128'((out_rk !== held_rk) || (out_tag !== held_tag)), 128'd0);
               end
               if (out_valid && out_ready) begin
                  if (exp_rk_q.size() == 0) begin
                     chk($sformatf("k%0d unexpected_out tag", KL), 128'(out_tag), 128'd0);
                  end else begin
                     e   = exp_rk_q.pop_front();
                     et  = exp_tag_q.pop_front();
                     ew  = e[RKW-1:0];
                     bad = 0;
                     for (int r = NRK - 1; r >= 0; r--)
                        if (out_rk[128*r +: 128] !== ew[128*r +: 128]) bad = r;
                     chk($sformatf("k%0d rk%0d", KL, bad), out_rk[128*bad +: 128],
                         ew[128*bad +: 128]);
                     chk($sformatf("k%0d tag", KL), 128'(out_tag), 128'(et));
                  end
               end
               stalled = out_valid && !out_ready;
               if (stalled) begin
                  held_rk  = out_rk;
                  held_tag = out_tag;
               end
            end
         end
      end

      initial begin : stim
         logic [255:0] kfull;
         int           lat;
         int           sent;
         int           cyc;
         bit           acc;
         rst_n     = 1'b1;
         in_valid  = 1'b0;
         in_key    = '0;
         in_tag    = '0;
         out_ready = 1'b1;
         #1 rst_n  = 1'b0;
         @(posedge clk); #1;
         chk($sformatf("k%0d reset out_valid", KL), 128'(out_valid), 128'd0);
         chk($sformatf("k%0d reset in_ready", KL), 128'(in_ready), 128'd1);
         chk($sformatf("k%0d reset out_rk_nonzero", KL), 128'(out_rk != '0), 128'd0);
         chk($sformatf("k%0d reset out_tag", KL), 128'(out_tag), 128'd0);

         // Known-answer key, offered in the first cycle after release.
         @(posedge clk); #1;
         rst_n    = 1'b1;
         kfull    = KAT_KEY;
         in_key   = kfull[KL-1:0];
         in_tag   = 32'h1234;
         in_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("k%0d first_accept", KL), 128'(in_ready), 128'd1);
         if (in_valid && in_ready) begin
            exp_rk_q.push_back(expand(kfull, NK));
            exp_tag_q.push_back(in_tag);
         end
         lat = 0;
         do begin
            @(posedge clk); #1;
            if (lat == 0) in_valid = 1'b0;
            lat++;
         end while (!out_valid && lat < NST + 10);
         chk($sformatf("k%0d kat latency", KL), 128'(lat), 128'(NST));
         chk($sformatf("k%0d kat last_rk", KL), out_rk[RKW-1 -: 128], KAT_RK);
         chk($sformatf("k%0d kat tag", KL), 128'(out_tag), 128'h1234);
         repeat (3) @(posedge clk);
         #1;

         // Eight back-to-back keys with a five-cycle output stall.
         for (int c = 0; c < NST + 16; c++) begin
            if (c < 8) begin
               for (int j = 0; j < 8; j++) kfull[32*j +: 32] = $urandom();
               in_key   = kfull[KL-1:0];
               in_tag   = $urandom();
               in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
            out_ready = !(c >= NST + 2 && c < NST + 7);
            @(negedge clk);
            if (in_valid && in_ready) begin
               exp_rk_q.push_back(expand(kfull, NK));
               exp_tag_q.push_back(in_tag);
            end
            if (c >= NST + 2 && c < NST + 7)
               chk($sformatf("k%0d stall in_ready", KL), 128'(in_ready), 128'd0);
            @(posedge clk); #1;
         end
         chk($sformatf("k%0d stall drained", KL), 128'(exp_rk_q.size()), 128'd0);

         // Reset with four keys in flight, the oldest held at the output.
         out_ready = 1'b0;
         for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 8; j++) kfull[32*j +: 32] = $urandom();
            in_key   = kfull[KL-1:0];
            in_tag   = $urandom();
            in_valid = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) begin
               exp_rk_q.push_back(expand(kfull, NK));
               exp_tag_q.push_back(in_tag);
            end
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         for (int c = 0; c < NST + 5 && !out_valid; c++) begin
            @(posedge clk); #1;
         end
         chk($sformatf("k%0d fill out_valid", KL), 128'(out_valid), 128'd1);
         rst_n = 1'b0;
         #1;
         chk($sformatf("k%0d async out_valid", KL), 128'(out_valid), 128'd0);
         chk($sformatf("k%0d async in_ready", KL), 128'(in_ready), 128'd1);
         chk($sformatf("k%0d async out_rk_nonzero", KL), 128'(out_rk != '0), 128'd0);
         exp_rk_q.delete();
         exp_tag_q.delete();
         @(posedge clk); #1;
         rst_n     = 1'b1;
         out_ready = 1'b1;
         for (int j = 0; j < 8; j++) kfull[32*j +: 32] = $urandom();
         in_key   = kfull[KL-1:0];
         in_tag   = $urandom();
         in_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("k%0d post_reset accept", KL), 128'(in_ready), 128'd1);
         if (in_valid && in_ready) begin
            exp_rk_q.push_back(expand(kfull, NK));
            exp_tag_q.push_back(in_tag);
         end
         lat = 0;
         do begin
            @(posedge clk); #1;
            if (lat == 0) in_valid = 1'b0;
            lat++;
         end while (!out_valid && lat < NST + 10);
         chk($sformatf("k%0d post_reset latency", KL), 128'(lat), 128'(NST));
         repeat (3) @(posedge clk);
         #1;

         // Random traffic against the model.
         sent = 0;
         cyc  = 0;
         while (sent < NKEYS && cyc < 80000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
               for (int j = 0; j < 8; j++) kfull[32*j +: 32] = $urandom();
               in_key   = kfull[KL-1:0];
               in_tag   = $urandom();
               in_valid = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) begin
               exp_rk_q.push_back(expand(kfull, NK));
               exp_tag_q.push_back(in_tag);
               sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) in_valid = 1'b0;
         end
         chk($sformatf("k%0d random sent", KL), 128'(sent), 128'(NKEYS));
         in_valid  = 1'b0;
         out_ready = 1'b1;
         repeat (NST + 4) @(posedge clk);
         #1;
         chk($sformatf("k%0d random drained", KL), 128'(exp_rk_q.size()), 128'd0);
         done[g] = 1'b1;
      end
   end

   initial begin : finisher
      int c;
      c = 0;
      while (!(done[0] && done[1] && done[2]) && c < 95000) begin
         @(posedge clk);
         c++;
      end
      chk("all_done", 128'(done[0] && done[1] && done[2]), 128'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_key_schedule_pipe.md
AES_KEY_SCHEDULE_PIPE -- requirements
Module: aes_key_schedule_pipe

Interface
REQ-001 SHALL have parameter KEYLEN, default 128, AES key length in bits; legal values are 128, 192 and 256.
REQ-002 SHALL have parameter TAG_W, default 32, width of the sideband tag (the candidate memory offset) that travels with each key.
REQ-003 SHALL have derived constants: NK = KEYLEN/32; NR = NK+6; NRK = NR+1 (11/13/15 round keys); NSTAGE = ceil((4*NRK-NK)/4) (10/12/13 stages).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_key and in_tag are valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the pipeline accepts input this cycle.
REQ-008 SHALL have port in_key, input, KEYLEN bits: cipher key; w[0] = in_key[KEYLEN-1:KEYLEN-32] (FIPS-197 byte order).
REQ-009 SHALL have port in_tag, input, TAG_W bits: opaque tag passed through unchanged.
REQ-010 SHALL have port out_valid, output, 1 bit: out_rk and out_tag are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the output.
REQ-012 SHALL have port out_rk, output, 128*NRK bits: round key r = words w[4r..4r+3] at bits [128r+127:128r], with w[4r] in the MSBs.
REQ-013 SHALL have port out_tag, output, TAG_W bits: tag of the key in out_rk.

Function
REQ-014 SHALL accept a key when in_valid && in_ready.
REQ-015 SHALL hold a word window and valid bit per stage; each stage SHALL compute the next 4 expanded words w[i] = w[i-NK] ^ temp.
- temp = SubWord(RotWord(w[i-1])) ^ Rcon[i/NK] when i mod NK == 0.
- temp = SubWord(w[i-1]) when NK == 8 and i mod NK == 4.
- temp = w[i-1] otherwise.
REQ-016 SHALL, in the final stage for KEYLEN=192, generate only the words up to index 4*NRK-1; excess words are not computed and not output.
REQ-017 SHALL make every stage carry forward all previously generated words and the tag, so all NRK round keys are presented simultaneously.
REQ-018 SHALL have a latency of exactly NSTAGE cycles from accept to out_valid when no stall occurs, and SHALL sustain a throughput of one key per cycle.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready).
REQ-020 SHALL advance every stage, including bubbles, when in_ready is 1, and SHALL freeze every stage (data and valid) when in_ready is 0.
REQ-021 SHALL insert a bubble (valid 0) into stage 1 when a stage advances with in_valid = 0.
REQ-022 SHALL keep out_rk and out_tag stable while out_valid && !out_ready, with no loss and no duplication.
REQ-023 SHALL, when out_ready is asserted in the same cycle as a stall release, advance the pipeline by one and accept input in that cycle.
REQ-024 SHALL keep the Rcon sequence at 01,02,04,08,10,20,40,80,1b,36, indexed by i/NK.

Reset
REQ-025 SHALL, on assertion of rst_n = 0, immediately clear all stage valid bits, and SHALL hold out_valid = 0 and in_ready = 1 during reset.
REQ-026 SHALL reset out_rk, out_tag and all stage data registers to 0.
REQ-027 SHALL discard in-flight keys on reset mid-operation, with no output produced for them after reset release.
REQ-028 SHALL accept input in the first cycle after rst_n is deasserted.

Structure
REQ-029 SHALL have package aes_ks_pkg hold: the S-box function, the Rcon table, and the functions nk_of(KEYLEN), nr_of(KEYLEN) and nstage_of(KEYLEN).
REQ-030 SHALL instantiate sub-module aes_ks_step once per stage (generate loop).
- aes_ks_step is combinational: window in, start index parameter, 4 new words out.
REQ-031 SHALL fail elaboration on an illegal KEYLEN.

Verification
REQ-032 SHALL cover KEYLEN=128 with key 2b7e151628aed2a6abf7158809cf4f3c, tag 0x1234 -> after 10 cycles out_valid=1, rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6, out_tag = 0x1234.
REQ-033 SHALL cover KEYLEN=192 with key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> after 12 cycles rk12 = e98ba06f448c773c8ecc720401002202.
REQ-034 SHALL cover KEYLEN=256 with key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> after 13 cycles rk14 = fe4890d1e6188d0b046df344706c631e.
REQ-035 SHALL cover back-to-back keys, out_ready=0 for 5 cycles mid-stream, then 1 -> in_ready=0 during the stall, outputs held stable, keys delivered in order with matching tags, none lost.
REQ-036 SHALL cover rst_n=0 asserted with 4 keys in flight -> out_valid=0 immediately; after release, no stale outputs and the first new key appears NSTAGE cycles after acceptance.
REQ-037 SHALL cover random keys with random in_valid/out_ready for 10k keys per KEYLEN -> all out_rk match the reference model.
